// File: rtl/sym_vn_lut_loader_if.sv
// ---------------------------------------------------------------------------
// sym_vn_lut_loader_if
// Valid/ready stream carrying LUT entries into the loader.
//   in_data  : one LUT entry (DATA_W bits)
//   in_valid : source has an entry on in_data
//   in_ready : loader accepts in_data this cycle
// Modports: master = entry source, slave = loader.
// ---------------------------------------------------------------------------
interface sym_vn_lut_loader_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sym_vn_lut_loader.sv
// ---------------------------------------------------------------------------
// sym_vn_lut_loader
// Streams LUT entries in pairs (bank0 entry, then bank1 entry) and writes
// each pair into two LUT banks at ascending addresses 0..LUT_DEPTH-1.
// One write takes at least three cycles: two accepts and one write cycle.
//
// Ports:
//   write_clk         : sole clock, rising edge
//   rstn              : asynchronous active-low reset
//   load_start        : one-cycle request to start a full load (ignored if busy)
//   in_bus            : entry stream (slave side)
//   lut_in_bank0/1    : registered write data for bank0/bank1
//   page_write_addr   : registered write address bits [5:0]
//   write_addr_offset : registered write address MSB
//   we                : write strobe, one cycle per address
//   busy              : load in progress
//   load_done         : one-cycle pulse after the last write
//   tables_valid      : both banks completely loaded
//
// Optional feature, macro SYM_VN_LOADER_CHECKSUM_EN:
//   exp_sum (in)  : expected modulo-256 sum of all accepted entries
//   sum_err (out) : registered at end of load, 1 when the sums differ;
//                   tables_valid is then withheld.
// ---------------------------------------------------------------------------
module sym_vn_lut_loader #(
  parameter int DATA_W    = 4,
  parameter int LUT_DEPTH = 128
) (
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              load_start,
  sym_vn_lut_loader_if.slave in_bus,
`ifdef SYM_VN_LOADER_CHECKSUM_EN
  input  logic [7:0]        exp_sum,
  output logic              sum_err,
`endif
  output logic [DATA_W-1:0] lut_in_bank0,
  output logic [DATA_W-1:0] lut_in_bank1,
  output logic [5:0]        page_write_addr,
  output logic              write_addr_offset,
  output logic              we,
  output logic              busy,
  output logic              load_done,
  output logic              tables_valid
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_B0 = 3'd1,
    ST_GET_B1 = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [6:0] LAST_ADDR = 7'(LUT_DEPTH - 1);

  state_t            state_r, state_nxt_s;
  logic [6:0]        addr_r, addr_nxt_s;
  logic [DATA_W-1:0] b0_r, b0_nxt_s;
  logic [DATA_W-1:0] b1_r, b1_nxt_s;
  logic              tv_r, tv_nxt_s;
  logic              in_ready_r, we_r, busy_r, load_done_r;
  logic [DATA_W-1:0] bank0_r, bank1_r;
  logic [6:0]        waddr_r;
  logic              accept_s;
`ifdef SYM_VN_LOADER_CHECKSUM_EN
  logic [7:0]        sum_r, sum_nxt_s;
  logic              sum_err_r, sum_err_nxt_s;
`endif

  // in_ready is registered, so a handshake only exists in the GET states
  assign accept_s = in_bus.in_valid & in_ready_r;

  // State register and internal datapath registers
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      addr_r  <= 7'd0;
      b0_r    <= '0;
      b1_r    <= '0;
      tv_r    <= 1'b0;
`ifdef SYM_VN_LOADER_CHECKSUM_EN
      sum_r     <= 8'd0;
      sum_err_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      b0_r    <= b0_nxt_s;
      b1_r    <= b1_nxt_s;
      tv_r    <= tv_nxt_s;
`ifdef SYM_VN_LOADER_CHECKSUM_EN
      sum_r     <= sum_nxt_s;
      sum_err_r <= sum_err_nxt_s;
`endif
    end
  end

  // Next-state, capture, counter and status logic
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    b0_nxt_s    = b0_r;
    b1_nxt_s    = b1_r;
    tv_nxt_s    = tv_r;
`ifdef SYM_VN_LOADER_CHECKSUM_EN
    sum_nxt_s     = sum_r;
    sum_err_nxt_s = sum_err_r;
    if (accept_s) begin
      sum_nxt_s = sum_r + 8'(in_bus.in_data);
    end else begin
      sum_nxt_s = sum_r;
    end
`endif
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt_s = ST_GET_B0;
          addr_nxt_s  = 7'd0;
          tv_nxt_s    = 1'b0;
`ifdef SYM_VN_LOADER_CHECKSUM_EN
          sum_nxt_s     = 8'd0;
          sum_err_nxt_s = 1'b0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GET_B0: begin
        if (accept_s) begin
          b0_nxt_s    = in_bus.in_data;
          state_nxt_s = ST_GET_B1;
        end else begin
          state_nxt_s = ST_GET_B0;
        end
      end
      ST_GET_B1: begin
        if (accept_s) begin
          b1_nxt_s    = in_bus.in_data;
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_GET_B1;
        end
      end
      ST_WRITE: begin
        // Status is resolved while leaving the last write so that
        // tables_valid/sum_err change together with the load_done pulse.
        if (addr_r == LAST_ADDR) begin
          state_nxt_s = ST_DONE;
`ifdef SYM_VN_LOADER_CHECKSUM_EN
          tv_nxt_s      = (sum_r == exp_sum);
          sum_err_nxt_s = (sum_r != exp_sum);
`else
          tv_nxt_s      = 1'b1;
`endif
        end else begin
          addr_nxt_s  = addr_r + 7'd1;
          state_nxt_s = ST_GET_B0;
        end
      end
      ST_DONE: begin
        addr_nxt_s  = 7'd0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output registers, decoded from the next state so they align with it
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      in_ready_r  <= 1'b0;
      we_r        <= 1'b0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
      bank0_r     <= '0;
      bank1_r     <= '0;
      waddr_r     <= 7'd0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_GET_B0) || (state_nxt_s == ST_GET_B1);
      we_r        <= (state_nxt_s == ST_WRITE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      load_done_r <= (state_nxt_s == ST_DONE);
      // Data/address only move when a write cycle begins; they hold otherwise
      if (state_nxt_s == ST_WRITE) begin
        bank0_r <= b0_nxt_s;
        bank1_r <= b1_nxt_s;
        waddr_r <= addr_nxt_s;
      end else begin
        bank0_r <= bank0_r;
        bank1_r <= bank1_r;
        waddr_r <= waddr_r;
      end
    end
  end

  assign in_bus.in_ready   = in_ready_r;
  assign we                = we_r;
  assign busy              = busy_r;
  assign load_done         = load_done_r;
  assign tables_valid      = tv_r;
  assign lut_in_bank0      = bank0_r;
  assign lut_in_bank1      = bank1_r;
  assign page_write_addr   = waddr_r[5:0];
  assign write_addr_offset = waddr_r[6];
`ifdef SYM_VN_LOADER_CHECKSUM_EN
  assign sum_err           = sum_err_r;
`endif

endmodule
